// File: rtl/change_dispenser.sv
// Coin-eject sequencer: unloads a stored change amount (5c units) to the hopper as timed
// quarter/dime/nickel eject pulses, largest denomination first.
module change_dispenser #(
    parameter int unsigned AMT_W     = 8,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             EN,
    input  logic             START,
    input  logic [AMT_W-1:0] AMOUNT,
    input  logic             HOPPER_RDY,
    output logic             COIN_Q,
    output logic             COIN_D,
    output logic             COIN_N,
    output logic             BUSY,
    output logic             DONE,
    output logic [AMT_W-1:0] REMAIN
);

    localparam int unsigned TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);

    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(2);
    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state,      state_nxt;
    logic [TMR_W-1:0] timer,      timer_nxt;
    logic [AMT_W-1:0] remain_nxt;
    logic             coin_q_nxt;
    logic             coin_d_nxt;
    logic             coin_n_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // State, timer and registered outputs; EN low freezes everything
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state  <= S_IDLE;
            timer  <= '0;
            REMAIN <= '0;
            COIN_Q <= 1'b0;
            COIN_D <= 1'b0;
            COIN_N <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else if (EN) begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            REMAIN <= remain_nxt;
            COIN_Q <= coin_q_nxt;
            COIN_D <= coin_d_nxt;
            COIN_N <= coin_n_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        remain_nxt = REMAIN;
        coin_q_nxt = COIN_Q;
        coin_d_nxt = COIN_D;
        coin_n_nxt = COIN_N;
        busy_nxt   = BUSY;
        done_nxt   = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (START) begin
                    remain_nxt = AMOUNT;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_SELECT;
                end
            end

            S_SELECT: begin
                busy_nxt = 1'b1;
                if (REMAIN == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else if (HOPPER_RDY) begin
                    // Greedy pick; each branch guarantees no underflow
                    if (REMAIN >= VAL_Q) begin
                        coin_q_nxt = 1'b1;
                        remain_nxt = REMAIN - VAL_Q;
                    end else if (REMAIN >= VAL_D) begin
                        coin_d_nxt = 1'b1;
                        remain_nxt = REMAIN - VAL_D;
                    end else begin
                        coin_n_nxt = 1'b1;
                        remain_nxt = REMAIN - VAL_N;
                    end
                    timer_nxt = PULSE_LOAD;
                    state_nxt = S_PULSE;
                end
            end

            S_PULSE: begin
                if (timer == '0) begin
                    coin_q_nxt = 1'b0;
                    coin_d_nxt = 1'b0;
                    coin_n_nxt = 1'b0;
                    timer_nxt  = GAP_LOAD;
                    state_nxt  = S_GAP;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            S_GAP: begin
                if (timer == '0) begin
                    state_nxt = S_SELECT;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                coin_q_nxt = 1'b0;
                coin_d_nxt = 1'b0;
                coin_n_nxt = 1'b0;
                busy_nxt   = 1'b0;
                timer_nxt  = '0;
                state_nxt  = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table, randomized transactions against a
// transaction-level model, and hand-written reset / START-held sequences.
module tb_change_dispenser;

    localparam int unsigned AMT_W     = 8;
    localparam int unsigned PULSE_CYC = 4;
    localparam int unsigned GAP_CYC   = 2;

    logic             CLK = 1'b0;
    logic             CLR_N;
    logic             EN;
    logic             START;
    logic [AMT_W-1:0] AMOUNT;
    logic             HOPPER_RDY;
    logic             COIN_Q;
    logic             COIN_D;
    logic             COIN_N;
    logic             BUSY;
    logic             DONE;
    logic [AMT_W-1:0] REMAIN;

    int total = 0;
    int bad   = 0;

    change_dispenser #(
        .AMT_W    (AMT_W),
        .PULSE_CYC(PULSE_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .EN        (EN),
        .START     (START),
        .AMOUNT    (AMOUNT),
        .HOPPER_RDY(HOPPER_RDY),
        .COIN_Q    (COIN_Q),
        .COIN_D    (COIN_D),
        .COIN_N    (COIN_N),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .REMAIN    (REMAIN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // en_mode: 0 always on, 1 random, 2 five-cycle stall mid first pulse
    // rdy_mode: 0 always ready, 1 random, 2 low for 10 enabled cycles after first coin
    // Timing is counted in enabled clock edges from the START-accepting edge (cycle 1 = SELECT).
    task automatic run_txn(input int amt, input int en_mode, input int rdy_mode,
                           output int nq, output int nd, output int nn, output int done_cyc);
        int exp_q[$];
        int owed, k, waits, gap_pre, plen, c, stall, lowcnt, act_val, exp_val, cnt;
        bit prev_high, high, en_nxt, rdy_nxt, last_en, stalled, waited, finished;
        logic [AMT_W+4:0] snap, now_v;

        nq = 0; nd = 0; nn = 0; done_cyc = -1;
        for (int i = 0; i < amt / 5; i++) exp_q.push_back(5);
        for (int i = 0; i < (amt % 5) / 2; i++) exp_q.push_back(2);
        if ((amt % 5) % 2 == 1) exp_q.push_back(1);

        @(negedge CLK);
        check("idle_busy", int'(BUSY), 0);
        START = 1'b1; AMOUNT = AMT_W'(amt); EN = 1'b1; HOPPER_RDY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        owed = amt; k = 0; waits = 0; gap_pre = 0; plen = 0; c = 1;
        stall = 0; lowcnt = 0; prev_high = 1'b0; last_en = 1'b1;
        stalled = 1'b0; waited = 1'b0; finished = 1'b0; snap = '0;

        for (int guard = 0; guard < 3000 && !finished; guard++) begin
            high  = COIN_Q | COIN_D | COIN_N;
            now_v = {COIN_Q, COIN_D, COIN_N, BUSY, DONE, REMAIN};
            cnt   = int'(COIN_Q) + int'(COIN_D) + int'(COIN_N);
            if (!last_en) check("en_freeze", int'(now_v), int'(snap));
            check("coin_onehot", int'(cnt <= 1), 1);
            check("busy_in_txn", int'(BUSY), 1);

            if (high && !prev_high) begin
                check("coin_latency", k, gap_pre + waits + 1);
                act_val = COIN_Q ? 5 : (COIN_D ? 2 : 1);
                if (exp_q.size() == 0) begin
                    check("extra_coin", act_val, 0);
                end else begin
                    exp_val = exp_q.pop_front();
                    check("coin_denom", act_val, exp_val);
                    owed -= exp_val;
                end
                check("remain", int'(REMAIN), owed);
                if (COIN_Q) nq++;
                else if (COIN_D) nd++;
                else nn++;
                plen = 0;
            end
            if (!high && prev_high) begin
                check("pulse_len", plen, int'(PULSE_CYC));
                k = 0; waits = 0; gap_pre = int'(GAP_CYC);
            end

            if (DONE) begin
                check("done_no_coin", int'(high), 0);
                check("done_latency", k, gap_pre + 1);
                check("coins_left", exp_q.size(), 0);
                done_cyc = c;
                finished = 1'b1;
            end else begin
                case (en_mode)
                    1: en_nxt = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (high && plen == 2 && !stalled) begin stall = 5; stalled = 1'b1; end
                        en_nxt = (stall == 0);
                        if (stall > 0) stall--;
                    end
                    default: en_nxt = 1'b1;
                endcase
                case (rdy_mode)
                    1: rdy_nxt = ($urandom_range(0, 2) != 0);
                    2: begin
                        if (!high && prev_high && !waited) begin lowcnt = 10; waited = 1'b1; end
                        rdy_nxt = (lowcnt == 0);
                        if (lowcnt > 0 && en_nxt) lowcnt--;
                    end
                    default: rdy_nxt = 1'b1;
                endcase
                if (en_nxt) begin
                    if (high) plen++;
                    else begin
                        if (k >= gap_pre && !rdy_nxt) waits++;
                        k++;
                    end
                    c++;
                end
                // START noise while busy must be ignored
                START  = ($urandom_range(0, 4) == 0);
                AMOUNT = AMT_W'($urandom);
                snap = now_v; last_en = en_nxt; prev_high = high;
                EN = en_nxt; HOPPER_RDY = rdy_nxt;
                @(negedge CLK);
            end
        end

        EN = 1'b1; START = 1'b0; HOPPER_RDY = 1'b1;
        if (!finished) begin
            check("txn_timeout", 0, 1);
        end else begin
            @(negedge CLK);
            check("post_done_busy", int'(BUSY), 0);
            check("post_done_pulse", int'(DONE), 0);
            check("post_done_remain", int'(REMAIN), 0);
        end
    endtask

    typedef struct {
        int amt;
        int en_mode;
        int rdy_mode;
        int nq;
        int nd;
        int nn;
        int done_cyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nq, nd, nn, dc, rises, amt;
        int busy_exp[5];
        int done_exp[5];
        bit prevq;

        vecs[0] = '{8,   0, 0,  1, 1, 1,  23};
        vecs[1] = '{0,   0, 0,  0, 0, 0,   2};
        vecs[2] = '{12,  0, 2,  2, 1, 0,  31};
        vecs[3] = '{8,   2, 0,  1, 1, 1,  23};
        vecs[4] = '{1,   0, 0,  0, 0, 1,   9};
        vecs[5] = '{4,   0, 0,  0, 2, 0,  16};
        vecs[6] = '{7,   0, 0,  1, 1, 0,  16};
        vecs[7] = '{3,   0, 0,  0, 1, 1,  16};
        vecs[8] = '{255, 0, 0, 51, 0, 0, 359};
        vecs[9] = '{10,  2, 2,  2, 0, 0,  24};

        busy_exp[0] = 1; busy_exp[1] = 1; busy_exp[2] = 0; busy_exp[3] = 1; busy_exp[4] = 1;
        done_exp[0] = 0; done_exp[1] = 1; done_exp[2] = 0; done_exp[3] = 0; done_exp[4] = 1;

        // Reset state
        CLR_N = 1'b0; EN = 1'b0; START = 1'b0; AMOUNT = '0; HOPPER_RDY = 1'b0;
        #12;
        check("rst_busy",   int'(BUSY),   0);
        check("rst_done",   int'(DONE),   0);
        check("rst_coins",  int'({COIN_Q, COIN_D, COIN_N}), 0);
        check("rst_remain", int'(REMAIN), 0);
        @(negedge CLK);
        CLR_N = 1'b1; EN = 1'b1; HOPPER_RDY = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            run_txn(vecs[i].amt, vecs[i].en_mode, vecs[i].rdy_mode, nq, nd, nn, dc);
            check($sformatf("vec%0d_nq", i), nq, vecs[i].nq);
            check($sformatf("vec%0d_nd", i), nd, vecs[i].nd);
            check($sformatf("vec%0d_nn", i), nn, vecs[i].nn);
            check($sformatf("vec%0d_done_cyc", i), dc, vecs[i].done_cyc);
        end

        // START held through DONE: re-accepted only from IDLE
        @(negedge CLK);
        START = 1'b1; AMOUNT = '0; EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("hold_busy_c%0d", i + 1), int'(BUSY), busy_exp[i]);
            check($sformatf("hold_done_c%0d", i + 1), int'(DONE), done_exp[i]);
        end
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check("hold_idle", int'(BUSY), 0);

        // Async reset during second quarter pulse
        START = 1'b1; AMOUNT = AMT_W'(20);
        @(negedge CLK);
        START = 1'b0;
        rises = 0; prevq = 1'b0;
        for (int g = 0; g < 60 && rises < 2; g++) begin
            @(negedge CLK);
            if (COIN_Q && !prevq) rises++;
            prevq = COIN_Q;
        end
        check("rst_mid_reached", rises, 2);
        @(negedge CLK);
        check("rst_mid_pre_q", int'(COIN_Q), 1);
        #2 CLR_N = 1'b0;
        #1;
        check("rst_mid_coin_q", int'(COIN_Q), 0);
        check("rst_mid_busy",   int'(BUSY),   0);
        check("rst_mid_remain", int'(REMAIN), 0);
        @(negedge CLK);
        CLR_N = 1'b1;
        run_txn(6, 0, 0, nq, nd, nn, dc);
        check("after_rst_nq", nq, 1);
        check("after_rst_nn", nn, 1);
        check("after_rst_done", dc, 16);

        // Randomized transactions
        for (int r = 0; r < 25; r++) begin
            amt = int'($urandom_range(0, 40));
            run_txn(amt, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), nq, nd, nn, dc);
            check("rand_nq", nq, amt / 5);
            check("rand_nd", nd, (amt % 5) / 2);
            check("rand_nn", nn, (amt % 5) % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
